// File: rtl/qcore_hazard_pkg.sv
// Shared types for the qcore forwarding/hazard slice: result-source enum,
// scoreboard entry layout and the readiness rule for in-flight results.
package qcore_hazard_pkg;

   // Scoreboard entries store addresses zero-extended to this width, so the
   // entry layout does not depend on a per-instance parameter.
   localparam int AW_MAX = 16;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'b00,
      SRC_DMEM = 2'b01,
      SRC_IMM  = 2'b11
   } src_t;

   typedef struct packed {
      logic              vld;
      logic [AW_MAX-1:0] addr;
      src_t              src;
   } sb_entry_t;

   // A DMEM result only exists from stage mem_lat on; every other source is
   // available as soon as it enters X1.
   function automatic logic is_ready(src_t src, int stage_idx, int mem_lat);
      return (src != SRC_DMEM) || (stage_idx >= mem_lat);
   endfunction

   // The reserved encoding 2'b10 behaves exactly like an ALU result.
   function automatic src_t norm_src(logic [1:0] raw);
      src_t s;
      case (raw)
         2'b01:   s = SRC_DMEM;
         2'b11:   s = SRC_IMM;
         default: s = SRC_ALU;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/qcore_fwd_scoreboard_if.sv
// Datapath <-> forwarding unit bundle: read ports, issue info, stage result
// buses and the forwarded operands / bubble request.
interface qcore_fwd_scoreboard_if #(
   parameter int NRD  = 3,
   parameter int DW   = 32,
   parameter int AW   = 7,
   parameter int NSTG = 4
);
   logic                     halt_i;
   logic [NRD-1:0][AW-1:0]   rs_addr_i;
   logic [NRD-1:0]           rs_vld_i;
   logic [NRD-1:0][DW-1:0]   rs_dt_i;
   logic                     iss_vld_i;
   logic                     iss_we_i;
   logic [AW-1:0]            iss_addr_i;
   logic [1:0]               iss_src_i;
   logic [NSTG-1:0][DW-1:0]  stg_dt_i;
   logic [NRD-1:0][DW-1:0]   rd_dt_o;
   logic                     bubble_o;

   modport master (
      output halt_i, rs_addr_i, rs_vld_i, rs_dt_i,
      output iss_vld_i, iss_we_i, iss_addr_i, iss_src_i, stg_dt_i,
      input  rd_dt_o, bubble_o
   );

   modport slave (
      input  halt_i, rs_addr_i, rs_vld_i, rs_dt_i,
      input  iss_vld_i, iss_we_i, iss_addr_i, iss_src_i, stg_dt_i,
      output rd_dt_o, bubble_o
   );
endinterface

// File: rtl/qcore_fwd_mux.sv
// One read port: find the youngest in-flight producer of the requested
// register and either forward its stage result or request a stall.
module qcore_fwd_mux
   import qcore_hazard_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 7,
   parameter int NSTG    = 4,
   parameter int MEM_LAT = 2
) (
   input  sb_entry_t [NSTG-1:0]          sb_i,
   input  logic      [AW-1:0]            rs_addr_i,
   input  logic      [DW-1:0]            rs_dt_i,
   input  logic      [NSTG-1:0][DW-1:0]  stg_dt_i,
   output logic      [DW-1:0]            next_dt_o,
   output logic                          stall_o
);

   // Walk oldest to youngest so the lowest matching stage overrides the rest.
   always_comb begin
      next_dt_o = rs_dt_i;
      stall_o   = 1'b0;
      for (int i = NSTG - 1; i >= 0; i--) begin
         if (sb_i[i].vld && (sb_i[i].addr == AW_MAX'(rs_addr_i))) begin
            if (is_ready(sb_i[i].src, i, MEM_LAT)) begin
               next_dt_o = stg_dt_i[i];
               stall_o   = 1'b0;
            end else begin
               next_dt_o = rs_dt_i;
               stall_o   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/qcore_fwd_scoreboard.sv
// Operand forwarding and hazard unit for the qcore pipeline.
// Tracks in-flight register writes across NSTG stages after RD, forwards the
// youngest ready result to each of NRD read ports and raises a bubble when a
// needed DMEM result does not exist yet.
// Optional build macro QCORE_HAZARD_STATS_EN adds stall statistics
// (stats_clr_i, stall_cnt_o, max_run_o).
module qcore_fwd_scoreboard
   import qcore_hazard_pkg::*;
#(
   parameter int NRD     = 3,
   parameter int DW      = 32,
   parameter int AW      = 7,
   parameter int NSTG    = 4,
   parameter int MEM_LAT = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
`ifdef QCORE_HAZARD_STATS_EN
   input  logic                 stats_clr_i,
   output logic [31:0]          stall_cnt_o,
   output logic [15:0]          max_run_o,
`endif
   qcore_fwd_scoreboard_if.slave bus
);

   if (MEM_LAT < 1 || MEM_LAT >= NSTG) begin : g_bad_mem_lat
      $error("qcore_fwd_scoreboard: MEM_LAT must lie in 1..NSTG-1");
   end
   if (AW > AW_MAX) begin : g_bad_aw
      $error("qcore_fwd_scoreboard: AW exceeds scoreboard address width");
   end

   sb_entry_t [NSTG-1:0]         sb_q;
   sb_entry_t                    new_entry;
   logic      [NRD-1:0][DW-1:0]  next_dt;
   logic      [NRD-1:0][DW-1:0]  rd_dt_q;
   logic      [NRD-1:0]          stall;
   logic                         bubble;

   // A bubble cycle pushes an invalid entry: the instruction stays in RD.
   assign new_entry = '{vld:  bus.iss_vld_i & bus.iss_we_i & ~bubble,
                        addr: AW_MAX'(bus.iss_addr_i),
                        src:  norm_src(bus.iss_src_i)};

   for (genvar p = 0; p < NRD; p++) begin : g_port
      qcore_fwd_mux #(
         .DW      (DW),
         .AW      (AW),
         .NSTG    (NSTG),
         .MEM_LAT (MEM_LAT)
      ) u_mux (
         .sb_i      (sb_q),
         .rs_addr_i (bus.rs_addr_i[p]),
         .rs_dt_i   (bus.rs_dt_i[p]),
         .stg_dt_i  (bus.stg_dt_i),
         .next_dt_o (next_dt[p]),
         .stall_o   (stall[p])
      );
   end

   // Only ports the instruction actually reads may hold it in RD.
   assign bubble       = |(bus.rs_vld_i & stall);
   assign bus.bubble_o = bubble;
   assign bus.rd_dt_o  = rd_dt_q;

   // Scoreboard shift: entries age one stage per advancing cycle, the one
   // leaving the last stage is owned by the register file from then on.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sb_q <= '0;
      end else if (!bus.halt_i) begin
         sb_q <= {sb_q[NSTG-2:0], new_entry};
      end
   end

   // Registered operands, updated even in bubble cycles (consumer ignores them).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_dt_q <= '0;
      end else if (!bus.halt_i) begin
         rd_dt_q <= next_dt;
      end
   end

`ifdef QCORE_HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [15:0] run_q;
   logic [15:0] max_q;
   logic [15:0] run_nxt;

   assign run_nxt     = (&run_q) ? run_q : run_q + 16'd1;
   assign stall_cnt_o = stall_cnt_q;
   assign max_run_o   = max_q;

   // Saturating stall counters; halted cycles neither count nor break a run.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         run_q       <= '0;
         max_q       <= '0;
      end else if (stats_clr_i) begin
         stall_cnt_q <= '0;
         run_q       <= '0;
         max_q       <= '0;
      end else if (!bus.halt_i) begin
         if (bubble) begin
            if (!(&stall_cnt_q)) begin
               stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            run_q <= run_nxt;
            if (run_nxt > max_q) begin
               max_q <= run_nxt;
            end
         end else begin
            run_q <= '0;
         end
      end
   end
`endif

endmodule
